uart_tx_fifo: RTL

Byte FIFO placed directly upstream of the UART transmitter. It absorbs bursts of bytes from a bus-side writer, such as an AHB-lite slave register, and drains them one at a time into the transmitter's `uart_in`/`uart_in_valid`/`tx_ready` handshake. This decouples writer timing from the serial line rate.

---
 rtl/uart_tx_fifo_if.sv | 35 +++
 rtl/uart_tx_fifo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Bus bundle for uart_tx_fifo: writer-side enqueue port, status flags,
// and the transmitter-side uart_in/uart_in_valid/tx_ready handshake.
// The slave modport is the FIFO; the master modport is whoever drives it.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Writer side
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          flush;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    // Transmitter side
    logic [7:0]    uart_in;
    logic          uart_in_valid;
    logic          tx_ready;

    // Overflow status
    logic          ovf;
    logic          ovf_clr;

    modport master (
        output wr_data, wr_en, flush, tx_ready, ovf_clr,
        input  full, empty, count, uart_in, uart_in_valid, ovf
    );

    modport slave (
        input  wr_data, wr_en, flush, tx_ready, ovf_clr,
        output full, empty, count, uart_in, uart_in_valid, ovf
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter.
//
// Storage is a DEPTH-entry array with a registered read whose output
// register doubles as uart_in. A byte written into an otherwise empty
// FIFO bypasses the array and lands directly in the output register so
// it is presented one cycle after the write. DEPTH counts the output
// register too, so the array never holds more than DEPTH-1 bytes and the
// read and write addresses never collide while both are active.
//
// Optional feature: define UART_TX_FIFO_OVF_EN to enable the sticky
// overflow flag. Without it, ovf is tied low and ovf_clr is ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input logic          clk,
    input logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage array and pointers
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;

    // Occupancy and flags
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          full_reg;
    logic          empty_reg;

    // Output stage
    logic [7:0]    out_reg;
    logic          valid_reg;

    // Overflow flag
    logic          ovf_reg;

    // Per-cycle decisions
    logic          push;
    logic          pop;
    logic          load_out;
    logic [CW-1:0] mem_count;
    logic          mem_has_data;
    logic          mem_rd;
    logic          mem_wr;
    logic          bypass;

    // Handshake decode and routing of the incoming/outgoing byte
    always_comb begin
        push         = bus.wr_en && !full_reg && !bus.flush;
        pop          = valid_reg && bus.tx_ready && !bus.flush;
        // The array holds everything except the byte sitting on uart_in.
        mem_count    = count_reg - CW'(valid_reg);
        mem_has_data = (mem_count != '0);
        // The output register can take a new byte when empty or being drained.
        load_out     = !valid_reg || pop;
        mem_rd       = load_out && mem_has_data && !bus.flush;
        // Only bypass when nothing older is waiting in the array.
        bypass       = load_out && !mem_has_data && push;
        mem_wr       = push && !bypass;
        count_next   = count_reg + CW'(push) - CW'(pop);
    end

    // Array write port; contents are not reset, pointers define validity
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    // Read/write pointers, wrapping naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (mem_rd) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    // Output register: registered array read, write bypass, or go idle
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg   <= 8'h00;
            valid_reg <= 1'b0;
        end else if (bus.flush) begin
            // Data is left as-is; only the valid qualifier drops.
            valid_reg <= 1'b0;
        end else if (load_out) begin
            if (mem_rd) begin
                out_reg   <= mem[rd_ptr_reg];
                valid_reg <= 1'b1;
            end else if (bypass) begin
                out_reg   <= bus.wr_data;
                valid_reg <= 1'b1;
            end else begin
                valid_reg <= 1'b0;
            end
        end
    end

    // Occupancy counter with registered full/empty derived from its next value
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            count_reg <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    // Sticky overflow: a write refused for lack of space sets it, and a
    // same-cycle clear loses to the set. Flush-dropped writes do not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (bus.wr_en && full_reg && !bus.flush) begin
            ovf_reg <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end
`else
    logic ovf_clr_unused;

    assign ovf_reg        = 1'b0;
    assign ovf_clr_unused = bus.ovf_clr;
`endif

    assign bus.full          = full_reg;
    assign bus.empty         = empty_reg;
    assign bus.count         = count_reg;
    assign bus.uart_in       = out_reg;
    assign bus.uart_in_valid = valid_reg;
    assign bus.ovf           = ovf_reg;

    // Structural invariants of the output stage and counter
    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count_reg <= CW'(DEPTH));
    a_valid_tracks_count: assert property (@(posedge clk) disable iff (rst)
        valid_reg == (count_reg != '0));
    a_flags_track_count: assert property (@(posedge clk) disable iff (rst)
        (empty_reg == (count_reg == '0)) && (full_reg == (count_reg == CW'(DEPTH))));
endmodule
